// File: rtl/alu_seq_ctrl_if.sv
// Bundle of command, ALU and response signals for alu_seq_ctrl.
// The "slave" modport is the sequencer's view; "master" is the surrounding logic (command source, ALU, consumer).
interface alu_seq_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op_sel;
  logic [7:0]       alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic [7:0]       done_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cnt,
    input  alu_result, alu_zero, alu_carry, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op_sel,
    output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, done_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cnt,
    output alu_result, alu_zero, alu_carry, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op_sel,
    input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, done_cnt
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Iterating command front-end for a combinational 8-bit ALU: result feeds back as operand a for cmd_cnt+1 passes.
// Optional macro ALU_SEQ_STICKY_EN: rsp_carry/rsp_overflow become the OR over all iterations.
module alu_seq_ctrl #(
  parameter int CNT_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_acc;
  logic [7:0]       r_b;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic             r_rsp_overflow;
  logic [7:0]       r_done_cnt;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_carry_fin;
  logic w_ovf_fin;

  assign w_cmd_fire = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_rsp_fire = r_rsp_valid && bus.rsp_ready;

`ifdef ALU_SEQ_STICKY_EN
  logic r_carry_stk;
  logic r_ovf_stk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_stk <= 1'b0;
      r_ovf_stk   <= 1'b0;
    end else if (w_cmd_fire) begin
      r_carry_stk <= 1'b0;
      r_ovf_stk   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_carry_stk <= r_carry_stk | bus.alu_carry;
      r_ovf_stk   <= r_ovf_stk | bus.alu_overflow;
    end
  end

  // The final iteration's flags are folded in combinationally at capture time
  assign w_carry_fin = r_carry_stk | bus.alu_carry;
  assign w_ovf_fin   = r_ovf_stk | bus.alu_overflow;
`else
  assign w_carry_fin = bus.alu_carry;
  assign w_ovf_fin   = bus.alu_overflow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_acc          <= 8'd0;
      r_b            <= 8'd0;
      r_op           <= 3'd0;
      r_rem          <= '0;
      r_cmd_ready    <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= 8'd0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_done_cnt     <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_acc       <= bus.cmd_a;
            r_b         <= bus.cmd_b;
            r_op        <= bus.cmd_op;
            r_rem       <= bus.cmd_cnt;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end else begin
            // cmd_ready stays low while in reset and rises on the first edge after release
            r_cmd_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_acc <= bus.alu_result;
          if (r_rem == '0) begin
            r_rsp_result   <= bus.alu_result;
            r_rsp_zero     <= bus.alu_zero;
            r_rsp_carry    <= w_carry_fin;
            r_rsp_overflow <= w_ovf_fin;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end else begin
            r_rem <= r_rem - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 8'd1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.alu_a        = r_acc;
  assign bus.alu_b        = r_b;
  assign bus.alu_op_sel   = r_op;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_carry    = r_rsp_carry;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.done_cnt     = r_done_cnt;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed literal cases plus random traffic against a
// transaction-level model; a stand-in 8-bit ALU closes the loop.
module tb_alu_seq_ctrl;
  localparam int CNT_W = 3;
`ifdef ALU_SEQ_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SHL = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  alu_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  alu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {zero, carry, overflow, result}
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = 9'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {(r == 8'd0), c, v, r};
  endfunction

  assign {bus.alu_zero, bus.alu_carry, bus.alu_overflow, bus.alu_result} =
      alu_ref(bus.alu_a, bus.alu_b, bus.alu_op_sel);

  // Whole-command result: apply the operation cnt+1 times, folding flags as the build requires
  function automatic logic [10:0] seq_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op, input int cnt);
    logic [10:0] step;
    logic [7:0]  acc;
    logic        cs, vs;
    acc = a;
    cs = 1'b0;
    vs = 1'b0;
    step = '0;
    for (int i = 0; i <= cnt; i++) begin
      step = alu_ref(acc, b, op);
      acc = step[7:0];
      cs = cs | step[9];
      vs = vs | step[8];
    end
    if (STICKY) return {step[10], cs, vs, acc};
    return step;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: command accepted -> response N edges later -> handshake -> ready
  logic        m_ready = 1'b0;
  logic        m_valid = 1'b0;
  int          m_wait = 0;
  logic [7:0]  m_done = 8'd0;
  logic [7:0]  m_b = 8'd0;
  logic [2:0]  m_op = 3'd0;
  logic [10:0] m_rsp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b0; m_valid = 1'b0; m_wait = 0; m_done = 8'd0;
      m_b = 8'd0; m_op = 3'd0; m_rsp = '0;
    end else if (m_valid) begin
      if (bus.rsp_ready) begin m_valid = 1'b0; m_done = m_done + 8'd1; m_ready = 1'b1; end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1'b1;
    end else if (m_ready && bus.cmd_valid) begin
      m_rsp = seq_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op, int'(bus.cmd_cnt));
      m_b = bus.cmd_b;
      m_op = bus.cmd_op;
      m_wait = int'(bus.cmd_cnt) + 1;
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", bus.cmd_ready, m_ready);
    chk("rsp_valid", bus.rsp_valid, m_valid);
    chk("done_cnt", bus.done_cnt, m_done);
    chk("alu_b", bus.alu_b, m_b);
    chk("alu_op_sel", bus.alu_op_sel, m_op);
    if (m_valid)
      chk("rsp_fields", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_result}, m_rsp);
    if (!rst_n) begin
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_rsp", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_result}, 32'd0);
    end
  end

  // Presents a command, waits for acceptance and for rsp_valid; lat = edges from accept to valid
  task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [CNT_W-1:0] cnt, input logic hold,
                        output logic [10:0] rsp, output int lat);
    int guard;
    @(negedge clk);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_cnt = cnt;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = ~hold;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!bus.cmd_ready) chk("accept_timeout", bus.cmd_ready, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) chk("rsp_timeout", bus.rsp_valid, 32'd1);
    rsp = {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_result};
    $display("cmd op=%0d a=%02h b=%02h cnt=%0d -> rsp=%03h lat=%0d", op, a, b, cnt, rsp, lat);
  endtask

  initial begin
    logic [10:0] rsp;
    int lat;
    int guard;
    bus.cmd_valid = 1'b0; bus.cmd_a = 8'd0; bus.cmd_b = 8'd0; bus.cmd_op = 3'd0;
    bus.cmd_cnt = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 32'd0);
    #1 rst_n = 1'b1;

    // Stalled response: SUB 5-5 -> 0 with zero flag, held for 5 cycles
    do_cmd(8'h05, 8'h05, OP_SUB, 3'd0, 1'b1, rsp, lat);
    chk("sub_result", rsp, {1'b1, 1'b0, 1'b0, 8'h00});
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_result}, rsp);
      chk("stall_valid", bus.rsp_valid, 32'd1);
      chk("stall_cmd_ready", bus.cmd_ready, 32'd0);
      chk("stall_done", bus.done_cnt, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_done", bus.done_cnt, 32'h01);
    chk("release_valid", bus.rsp_valid, 32'd0);
    chk("release_ready", bus.cmd_ready, 32'd1);

    do_cmd(8'h10, 8'h05, OP_ADD, 3'd0, 1'b0, rsp, lat);
    chk("add1_result", rsp, {1'b0, 1'b0, 1'b0, 8'h15});
    chk("add1_latency", lat, 32'd1);

    do_cmd(8'h00, 8'h40, OP_ADD, 3'd2, 1'b0, rsp, lat);
    chk("add3_result", rsp, {1'b0, 1'b0, STICKY, 8'hC0});
    chk("add3_latency", lat, 32'd3);

    do_cmd(8'h81, 8'h00, OP_SHL, 3'd1, 1'b0, rsp, lat);
    chk("shl2_result", rsp, {1'b0, STICKY, 1'b0, 8'h04});

    // Random traffic with random back-pressure, checked every cycle by the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_a = 8'($urandom);
      bus.cmd_b = 8'($urandom);
      bus.cmd_op = 3'($urandom);
      bus.cmd_cnt = CNT_W'($urandom);
      bus.rsp_ready = $urandom_range(0, 1) == 1;
      if (bus.rsp_valid) $display("rand rsp=%03h done=%0d", {bus.rsp_zero, bus.rsp_carry,
                                  bus.rsp_overflow, bus.rsp_result}, bus.done_cnt);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("drain_idle", bus.cmd_ready, 32'd1);

    // Asynchronous reset in the middle of a long command
    @(negedge clk);
    bus.cmd_a = 8'h33; bus.cmd_b = 8'h11; bus.cmd_op = OP_ADD; bus.cmd_cnt = 3'd7;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.rsp_valid, 32'd0);
    chk("midrst_ready", bus.cmd_ready, 32'd0);
    chk("midrst_alu", {bus.alu_a, bus.alu_b, 5'd0, bus.alu_op_sel}, 32'd0);
    chk("midrst_rsp", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_result}, 32'd0);
    chk("midrst_done", bus.done_cnt, 32'd0);
    $display("async reset asserted during EXEC");
    @(negedge clk);
    #1 rst_n = 1'b1;

    do_cmd(8'h01, 8'h01, OP_ADD, 3'd0, 1'b0, rsp, lat);
    chk("post_rst_result", rsp, {1'b0, 1'b0, 1'b0, 8'h02});
    @(negedge clk);
    chk("post_rst_done", bus.done_cnt, 32'h01);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
